// File: rtl/fetch_prefetch_queue.sv
// Fetch stage with a DEPTH-entry prefetch queue between instruction memory and decode.
// Redirects flush the queue, drop any in-flight response and advance the redirect tag.
module fetch_prefetch_queue #(
    parameter logic [31:0] START_ADDRESS = 32'h0000_0000,
    parameter int          DEPTH         = 4,
    parameter int          TAG_WIDTH     = 3
) (
    input  logic                 clk,
    input  logic                 sys_reset,
    input  logic                 machine_return_i,
    input  logic [31:0]          mepc_i,
    input  logic                 exception_raised_i,
    input  logic                 interrupt_ack_i,
    input  logic [31:0]          mtvec_i,
    input  logic                 jump_i,
    input  logic [31:0]          jump_target_i,
    output logic                 instr_req_o,
    output logic [31:0]          instruction_address_o,
    input  logic                 instr_gnt_i,
    input  logic [31:0]          instr_data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [31:0]          instruction_o,
    output logic [31:0]          pc_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 jumped_o,
    output logic                 jump_misaligned_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    // Queue storage: data only, never reset
    logic [31:0]          ins_mem   [DEPTH];
    logic [31:0]          pc_mem    [DEPTH];
    logic [TAG_WIDTH-1:0] tag_mem   [DEPTH];
    logic                 first_mem [DEPTH];
    logic                 misal_mem [DEPTH];

    logic [31:0]          pc_q, pc_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [CW-1:0]        count_q, count_d;
    logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic                 inflight_q, inflight_d;
    logic                 first_q, first_d;
    logic                 misal_q, misal_d;

    logic [31:0]          lat_pc_q;
    logic [TAG_WIDTH-1:0] lat_tag_q;
    logic                 lat_first_q, lat_misal_q;

    logic        redirect, pop, push, grant;
    logic [31:0] target;
    logic [CW:0] occupancy;

    assign redirect = machine_return_i | exception_raised_i | interrupt_ack_i | jump_i;

    always_comb begin
        target = jump_target_i;
        if (exception_raised_i || interrupt_ack_i) target = mtvec_i;
        if (machine_return_i) target = mepc_i;
    end

    assign valid_o   = (count_q != '0);
    assign pop       = valid_o & ready_i;
    assign push      = inflight_q & ~redirect;
    // Slots already promised to queued entries plus the outstanding response
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};

    assign instr_req_o           = !redirect && !sys_reset && (occupancy < DEPTH_C);
    assign instruction_address_o = pc_q;
    assign grant                 = instr_req_o & instr_gnt_i;

    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        count_d    = count_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        inflight_d = 1'b0;
        first_d    = first_q;
        misal_d    = misal_q;
        if (redirect) begin
            pc_d    = {target[31:2], 2'b00};
            tag_d   = tag_q + 1'b1;
            count_d = '0;
            wr_d    = '0;
            rd_d    = '0;
            first_d = 1'b1;
            misal_d = (target[1:0] != 2'b00);
        end else begin
            if (grant) begin
                pc_d       = pc_q + 32'd4;
                inflight_d = 1'b1;
                first_d    = 1'b0;
                misal_d    = 1'b0;
            end
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            pc_q       <= START_ADDRESS;
            tag_q      <= '0;
            count_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            inflight_q <= 1'b0;
            first_q    <= 1'b1;
            misal_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            count_q    <= count_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            inflight_q <= inflight_d;
            first_q    <= first_d;
            misal_q    <= misal_d;
        end
    end

    // Attributes of the granted fetch, paired with its data one cycle later
    always_ff @(posedge clk) begin
        if (grant) begin
            lat_pc_q    <= pc_q;
            lat_tag_q   <= tag_q;
            lat_first_q <= first_q;
            lat_misal_q <= misal_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[wr_q]   <= instr_data_i;
            pc_mem[wr_q]    <= lat_pc_q;
            tag_mem[wr_q]   <= lat_tag_q;
            first_mem[wr_q] <= lat_first_q;
            misal_mem[wr_q] <= lat_misal_q;
        end
    end

    assign instruction_o     = valid_o ? ins_mem[rd_q]   : 32'd0;
    assign pc_o              = valid_o ? pc_mem[rd_q]    : 32'd0;
    assign tag_o             = valid_o ? tag_mem[rd_q]   : '0;
    assign jumped_o          = valid_o ? first_mem[rd_q] : 1'b0;
    assign jump_misaligned_o = valid_o ? misal_mem[rd_q] : 1'b0;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomised scoreboard bench for fetch_prefetch_queue against a queue-based reference model.
module tb_fetch_prefetch_queue;
    localparam logic [31:0] START = 32'h0000_0000;
    localparam int DEPTH = 4;
    localparam int TW    = 3;

    logic          clk = 1'b0;
    logic          sys_reset = 1'b1;
    logic          machine_return_i = 1'b0, exception_raised_i = 1'b0;
    logic          interrupt_ack_i = 1'b0, jump_i = 1'b0;
    logic [31:0]   mepc_i = '0, mtvec_i = '0, jump_target_i = '0;
    logic          instr_gnt_i = 1'b1, ready_i = 1'b1;
    logic [31:0]   instr_data_i = '0;
    logic          instr_req_o, valid_o, jumped_o, jump_misaligned_o;
    logic [31:0]   instruction_address_o, instruction_o, pc_o;
    logic [TW-1:0] tag_o;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(.START_ADDRESS(START), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
        .clk(clk), .sys_reset(sys_reset),
        .machine_return_i(machine_return_i), .mepc_i(mepc_i),
        .exception_raised_i(exception_raised_i), .interrupt_ack_i(interrupt_ack_i),
        .mtvec_i(mtvec_i), .jump_i(jump_i), .jump_target_i(jump_target_i),
        .instr_req_o(instr_req_o), .instruction_address_o(instruction_address_o),
        .instr_gnt_i(instr_gnt_i), .instr_data_i(instr_data_i),
        .valid_o(valid_o), .ready_i(ready_i), .instruction_o(instruction_o),
        .pc_o(pc_o), .tag_o(tag_o), .jumped_o(jumped_o),
        .jump_misaligned_o(jump_misaligned_o)
    );

    typedef struct {
        logic [31:0]   ins;
        logic [31:0]   pc;
        logic [TW-1:0] tag;
        logic          first;
        logic          misal;
    } ent_t;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        vld;
        ent_t        head;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];

    logic [31:0]   m_pc = START;
    logic [TW-1:0] m_tag = '0;
    logic          m_infl = 1'b0, m_first = 1'b1, m_misal = 1'b0;
    ent_t          m_lat;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: evaluated mid-cycle with this cycle's inputs, records the expected
    // outputs of the cycle, then advances to the state after the coming clock edge.
    task automatic model_step();
        exp_t        e;
        logic        redir, pop, req;
        logic [31:0] tgt;
        ent_t        blank;
        blank = '{ins: '0, pc: '0, tag: '0, first: 1'b0, misal: 1'b0};
        redir = machine_return_i | exception_raised_i | interrupt_ack_i | jump_i;
        pop   = (mq.size() > 0) && ready_i;
        req   = !redir && !sys_reset && ((mq.size() + int'(m_infl) - int'(pop)) < DEPTH);
        e.req  = req;
        e.addr = m_pc;
        e.vld  = (mq.size() > 0);
        e.head = (mq.size() > 0) ? mq[0] : blank;
        sb.push_back(e);

        if (sys_reset) begin
            m_pc = START; m_tag = '0; mq.delete(); m_infl = 1'b0; m_first = 1'b1; m_misal = 1'b0;
        end else if (redir) begin
            if (machine_return_i) tgt = mepc_i;
            else if (exception_raised_i || interrupt_ack_i) tgt = mtvec_i;
            else tgt = jump_target_i;
            m_pc    = {tgt[31:2], 2'b00};
            m_tag   = m_tag + 1'b1;
            mq.delete();
            m_infl  = 1'b0;
            m_first = 1'b1;
            m_misal = (tgt[1:0] != 2'b00);
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_infl) begin
                m_lat.ins = instr_data_i;
                mq.push_back(m_lat);
            end
            if (req && instr_gnt_i) begin
                m_lat   = '{ins: '0, pc: m_pc, tag: m_tag, first: m_first, misal: m_misal};
                m_pc    = m_pc + 32'd4;
                m_first = 1'b0;
                m_misal = 1'b0;
                m_infl  = 1'b1;
            end else begin
                m_infl = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        instr_data_i = $urandom;
    endtask

    task automatic no_redirect();
        machine_return_i = 1'b0; exception_raised_i = 1'b0;
        interrupt_ack_i = 1'b0; jump_i = 1'b0;
    endtask

    // Monitor: compares DUT outputs against the expectation recorded for each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("valid_o", 32'(valid_o), 32'(e.vld));
                chk("instr_req_o", 32'(instr_req_o), 32'(e.req));
                if (e.req) chk("instruction_address_o", instruction_address_o, e.addr);
                if (e.vld) begin
                    chk("instruction_o", instruction_o, e.head.ins);
                    chk("pc_o", pc_o, e.head.pc);
                    chk("tag_o", 32'(tag_o), 32'(e.head.tag));
                    chk("jumped_o", 32'(jumped_o), 32'(e.head.first));
                    chk("jump_misaligned_o", 32'(jump_misaligned_o), 32'(e.head.misal));
                end
            end
        end
    end

    initial begin
        int r;
        m_lat = '{ins: '0, pc: '0, tag: '0, first: 1'b0, misal: 1'b0};
        tick();
        tick();
        chk("reset valid_o", 32'(valid_o), 32'd0);
        chk("reset instr_req_o", 32'(instr_req_o), 32'd0);
        chk("reset instruction_o", instruction_o, 32'd0);
        chk("reset pc_o", pc_o, 32'd0);
        chk("reset tag_o", 32'(tag_o), 32'd0);
        chk("reset jumped_o", 32'(jumped_o), 32'd0);
        chk("reset jump_misaligned_o", 32'(jump_misaligned_o), 32'd0);
        sys_reset = 1'b0;

        for (int i = 0; i < 12; i++) tick();

        ready_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        ready_i = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        jump_i = 1'b1; jump_target_i = 32'h0000_0102;
        tick();
        no_redirect(); ready_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        machine_return_i = 1'b1; mepc_i = 32'h0000_0200;
        jump_i = 1'b1; jump_target_i = 32'h0000_0300;
        tick();
        no_redirect();
        for (int i = 0; i < 6; i++) tick();

        for (int i = 0; i < 8; i++) begin
            jump_i = 1'b1; jump_target_i = 32'h0000_1000 + 32'(i * 16);
            tick();
            no_redirect();
            tick();
        end
        for (int i = 0; i < 6; i++) tick();

        jump_i = 1'b1; jump_target_i = 32'hFFFF_FFFC;
        tick();
        no_redirect();
        for (int i = 0; i < 6; i++) tick();

        for (int i = 0; i < 3; i++) tick();
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        for (int n = 0; n < 3000; n++) begin
            ready_i     = ($urandom_range(0, 3) != 0);
            instr_gnt_i = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 99));
            machine_return_i   = (r < 3) || (r == 50);
            exception_raised_i = (r >= 3 && r < 6) || (r == 50) || (r == 51);
            interrupt_ack_i    = (r >= 6 && r < 8);
            jump_i             = (r >= 8 && r < 12) || (r == 51);
            mepc_i        = $urandom;
            mtvec_i       = $urandom;
            jump_target_i = $urandom;
            sys_reset     = ($urandom_range(0, 199) == 0);
            tick();
        end
        no_redirect();
        sys_reset = 1'b0;
        tick();
        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
